odd_issue_scheduler: RTL and testbench

//  Issue controller in front of the odd pipe (Permute, LocalStore, Branch). Accepts one decoded

---
 rtl/odd_issue_scheduler_pkg.sv | 49 ++++
 rtl/odd_issue_scheduler_if.sv | 50 +++++
 rtl/odd_issue_scheduler_scoreboard.sv | 82 ++++++++
 rtl/odd_issue_scheduler.sv | 144 ++++++++++++++
 tb/tb_odd_issue_scheduler.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/odd_issue_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : odd_sched_pkg
//  Purpose  : Shared types and constants for the odd-pipe issue scheduler:
//             execution-unit encoding, forwarding latencies, scoreboard slot
//             layout and controller states.
//  Revision : 1.0 - initial release
// ============================================================================
package odd_sched_pkg;

   typedef enum logic [1:0] {
      PERM  = 2'd0,
      LS    = 2'd1,
      BR    = 2'd2,
      UNDEF = 2'd3
   } unit_e;

   localparam int PERM_LAT_DEF = 4;
   localparam int LS_LAT_DEF   = 6;
   localparam int BR_LAT_DEF   = 1;
   localparam int N_SLOTS_DEF  = 8;
   localparam int REM_MAX      = 7;

   typedef struct packed {
      logic       valid;
      logic [6:0] addr;
      logic [2:0] rem;
   } slot_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Forwarding latency of a unit; the unused encoding behaves as a Permute.
   function automatic logic [2:0] unit_lat(input logic [1:0] unit,
                                           input int perm_lat,
                                           input int ls_lat,
                                           input int br_lat);
      case (unit)
         2'd1:    return 3'(ls_lat);
         2'd2:    return 3'(br_lat);
         default: return 3'(perm_lat);
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/odd_issue_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : odd_issue_scheduler_if
//  Purpose  : Decode-side handshake, registered issue bus and drain/flush
//             control for the odd-pipe issue scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
interface odd_issue_scheduler_if;

   logic        dec_valid;
   logic        dec_ready;
   logic [0:10] dec_op;
   logic [2:0]  dec_format;
   logic [1:0]  dec_unit;
   logic [6:0]  dec_rt_addr;
   logic        dec_reg_write;
   logic [6:0]  dec_ra_addr;
   logic [6:0]  dec_rb_addr;
   logic [6:0]  dec_rc_addr;
   logic [2:0]  dec_src_use;

   logic        iss_valid;
   logic [0:10] iss_op;
   logic [2:0]  iss_format;
   logic [1:0]  iss_unit;
   logic [6:0]  iss_rt_addr;
   logic        iss_reg_write;

   logic        flush;
   logic        drain_req;
   logic        drain_done;
   logic        busy;
   logic [15:0] stall_cnt;

   modport master (
      output dec_valid, dec_op, dec_format, dec_unit, dec_rt_addr, dec_reg_write,
             dec_ra_addr, dec_rb_addr, dec_rc_addr, dec_src_use, flush, drain_req,
      input  dec_ready, iss_valid, iss_op, iss_format, iss_unit, iss_rt_addr,
             iss_reg_write, drain_done, busy, stall_cnt
   );

   modport slave (
      input  dec_valid, dec_op, dec_format, dec_unit, dec_rt_addr, dec_reg_write,
             dec_ra_addr, dec_rb_addr, dec_rc_addr, dec_src_use, flush, drain_req,
      output dec_ready, iss_valid, iss_op, iss_format, iss_unit, iss_rt_addr,
             iss_reg_write, drain_done, busy, stall_cnt
   );

endinterface
`default_nettype wire

// File: rtl/odd_issue_scheduler_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : odd_scoreboard
//  Purpose  : Latency-countdown scoreboard of in-flight destinations.
//             Allocates the lowest free slot, counts every valid slot down
//             once per cycle, and reports source/destination matches.
//  Revision : 1.0 - initial release
// ============================================================================
module odd_scoreboard
   import odd_sched_pkg::*;
#(
   parameter int N_SLOTS = N_SLOTS_DEF
) (
   input  wire logic       clk,
   input  wire logic       reset,
   input  wire logic       alloc,
   input  wire logic [6:0] alloc_addr,
   input  wire logic [2:0] alloc_rem,
   input  wire logic [6:0] ra_addr,
   input  wire logic [6:0] rb_addr,
   input  wire logic [6:0] rc_addr,
   input  wire logic [6:0] rt_addr,
   input  wire logic [2:0] src_use,
   input  wire logic       reg_write,
   output logic [3:0]      match,      // {ra, rb, rc, rt}
   output logic            busy,
   output logic            nofree
);

   slot_t              slots [N_SLOTS];
   logic [N_SLOTS-1:0] valid_vec;
   logic [N_SLOTS-1:0] alloc_sel;
   logic               free_found;

   // Pick the lowest-numbered free slot as the allocation target.
   always_comb begin
      alloc_sel  = '0;
      free_found = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (!slots[i].valid && !free_found) begin
            alloc_sel[i] = 1'b1;
            free_found   = 1'b1;
         end
      end
   end

   // Compare every valid slot against the used sources and the destination.
   always_comb begin
      match = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (slots[i].valid) begin
            if (src_use[2] && slots[i].addr == ra_addr) match[3] = 1'b1;
            if (src_use[1] && slots[i].addr == rb_addr) match[2] = 1'b1;
            if (src_use[0] && slots[i].addr == rc_addr) match[1] = 1'b1;
            if (reg_write  && slots[i].addr == rt_addr) match[0] = 1'b1;
         end
      end
   end

   generate
      for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
         assign valid_vec[g] = slots[g].valid;

         // Count down while valid, free on the 1->0 step, otherwise accept a new load.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               slots[g] <= '0;
            end else if (slots[g].valid) begin
               slots[g].rem <= slots[g].rem - 3'd1;
               if (slots[g].rem == 3'd1) slots[g].valid <= 1'b0;
            end else if (alloc && alloc_sel[g]) begin
               slots[g] <= '{valid: 1'b1, addr: alloc_addr, rem: alloc_rem};
            end
         end
      end
   endgenerate

   assign busy   = |valid_vec;
   assign nofree = reg_write && (&valid_vec);

endmodule
`default_nettype wire

// File: rtl/odd_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : odd_issue_scheduler
//  Purpose  : Issue controller for the odd pipe (Permute / LocalStore /
//             Branch). Holds decode on RAW/WAW hazards against in-flight
//             producers, supports branch flush and a drain handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module odd_issue_scheduler
   import odd_sched_pkg::*;
#(
   parameter int PERM_LAT = PERM_LAT_DEF,
   parameter int LS_LAT   = LS_LAT_DEF,
   parameter int BR_LAT   = BR_LAT_DEF,
   parameter int N_SLOTS  = N_SLOTS_DEF
) (
   input  wire logic             clk,
   input  wire logic             reset,
   odd_issue_scheduler_if.slave  bus
);

   localparam int MAX_LAT = (LS_LAT > PERM_LAT) ? ((LS_LAT > BR_LAT) ? LS_LAT : BR_LAT)
                                                : ((PERM_LAT > BR_LAT) ? PERM_LAT : BR_LAT);

   generate
      if (PERM_LAT > REM_MAX || LS_LAT > REM_MAX || BR_LAT > REM_MAX ||
          PERM_LAT < 1 || LS_LAT < 1 || BR_LAT < 1) begin : g_bad_lat
         $error("odd_issue_scheduler: latencies must lie in 1..7");
      end
      if (N_SLOTS < MAX_LAT) begin : g_bad_slots
         $error("odd_issue_scheduler: N_SLOTS must be >= max latency");
      end
   endgenerate

   state_e      state;
   state_e      state_next;
   logic [3:0]  match;
   logic        nofree;
   logic        busy;
   logic        hazard;
   logic        accept;
   logic        alloc;
   logic [2:0]  lat;
   logic [15:0] stall_cnt;

   logic        iss_valid;
   logic [0:10] iss_op;
   logic [2:0]  iss_format;
   logic [1:0]  iss_unit;
   logic [6:0]  iss_rt_addr;
   logic        iss_reg_write;

   // The load edge itself is the first countdown step, so a slot holds LAT-1
   // and a dependent may issue exactly LAT cycles after its producer. A
   // single-cycle producer never needs a slot at all.
   assign lat    = unit_lat(bus.dec_unit, PERM_LAT, LS_LAT, BR_LAT);
   assign hazard = (|match) || nofree;
   assign bus.dec_ready = !reset && (state == RUN || state == STALL) &&
                          !hazard && !bus.drain_req && !bus.flush;
   assign accept = bus.dec_valid && bus.dec_ready;
   assign alloc  = accept && bus.dec_reg_write && (lat > 3'd1);

   odd_scoreboard #(.N_SLOTS(N_SLOTS)) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .alloc      (alloc),
      .alloc_addr (bus.dec_rt_addr),
      .alloc_rem  (lat - 3'd1),
      .ra_addr    (bus.dec_ra_addr),
      .rb_addr    (bus.dec_rb_addr),
      .rc_addr    (bus.dec_rc_addr),
      .rt_addr    (bus.dec_rt_addr),
      .src_use    (bus.dec_src_use),
      .reg_write  (bus.dec_reg_write),
      .match      (match),
      .busy       (busy),
      .nofree     (nofree)
   );

   // Controller state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_next;
   end

   // Next state: drain beats flush, flush beats a stall.
   always_comb begin
      state_next = state;
      case (state)
         RUN, STALL: begin
            if (bus.drain_req)                   state_next = DRAIN;
            else if (bus.flush)                  state_next = RUN;
            else if (bus.dec_valid && hazard)    state_next = STALL;
            else                                 state_next = RUN;
         end
         DRAIN: begin
            if (!bus.drain_req) state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   // Issue register: one-cycle valid pulse, payload holds between issues.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iss_valid     <= 1'b0;
         iss_op        <= '0;
         iss_format    <= '0;
         iss_unit      <= '0;
         iss_rt_addr   <= '0;
         iss_reg_write <= 1'b0;
      end else begin
         iss_valid <= accept;
         if (accept) begin
            iss_op        <= bus.dec_op;
            iss_format    <= bus.dec_format;
            iss_unit      <= bus.dec_unit;
            iss_rt_addr   <= bus.dec_rt_addr;
            iss_reg_write <= bus.dec_reg_write;
         end
      end
   end

   // Saturating count of cycles a presented instruction is held by a hazard.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (bus.dec_valid && hazard && !bus.flush && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign bus.iss_valid     = iss_valid;
   assign bus.iss_op        = iss_op;
   assign bus.iss_format    = iss_format;
   assign bus.iss_unit      = iss_unit;
   assign bus.iss_rt_addr   = iss_rt_addr;
   assign bus.iss_reg_write = iss_reg_write;
   assign bus.busy          = busy;
   assign bus.drain_done    = bus.drain_req && !busy;
   assign bus.stall_cnt     = stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_odd_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_odd_issue_scheduler
//  Purpose  : Self-checking bench for odd_issue_scheduler: directed hazard,
//             flush and drain scenarios with an issue-packet scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_odd_issue_scheduler;
   import odd_sched_pkg::*;

   logic clk = 1'b0;
   logic reset;

   odd_issue_scheduler_if bus();

   odd_issue_scheduler #(
      .PERM_LAT (4),
      .LS_LAT   (6),
      .BR_LAT   (1),
      .N_SLOTS  (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [0:10] op;
      logic [2:0]  fmt;
      logic [1:0]  unit;
      logic [6:0]  rt;
      logic        wr;
   } iss_t;

   iss_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every issued packet must match the oldest accepted instruction.
   always @(posedge clk) begin : mon
      iss_t e;
      #1;
      if (!reset && bus.iss_valid) begin
         if (exp_q.size() == 0) begin
            check("iss_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("iss_pkt", {8'h0, bus.iss_op, bus.iss_format, bus.iss_unit,
                              bus.iss_rt_addr, bus.iss_reg_write}, {8'h0, e});
         end
      end
   end

   // Present one instruction (called right after a falling edge) and count
   // the cycles it is held before acceptance.
   task automatic send(input string tag, input logic [1:0] unit, input logic [6:0] rt,
                       input logic wr, input logic [6:0] ra, input logic [6:0] rb,
                       input logic [6:0] rc, input logic [2:0] src_use, input int exp_wait);
      iss_t e;
      int   waits = 0;
      bit   done  = 1'b0;
      bus.dec_op        = 11'($urandom);
      bus.dec_format    = 3'($urandom);
      bus.dec_unit      = unit;
      bus.dec_rt_addr   = rt;
      bus.dec_reg_write = wr;
      bus.dec_ra_addr   = ra;
      bus.dec_rb_addr   = rb;
      bus.dec_rc_addr   = rc;
      bus.dec_src_use   = src_use;
      bus.dec_valid     = 1'b1;
      e.op   = bus.dec_op;
      e.fmt  = bus.dec_format;
      e.unit = unit;
      e.rt   = rt;
      e.wr   = wr;
      while (!done) begin
         #1;
         if (bus.dec_ready) begin
            exp_q.push_back(e);
            @(negedge clk);
            done = 1'b1;
         end else if (waits >= 40) begin
            check({tag, "_timeout"}, 32'd1, 32'd0);
            @(negedge clk);
            done = 1'b1;
         end else begin
            waits++;
            @(negedge clk);
         end
      end
      bus.dec_valid = 1'b0;
      check({tag, "_wait"}, 32'(waits), 32'(exp_wait));
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) check({tag, "_idle_timeout"}, 32'd1, 32'd0);
      @(negedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [15:0] base;
      bus.dec_valid     = 1'b1;
      bus.dec_op        = 11'h5A5;
      bus.dec_format    = 3'd2;
      bus.dec_unit      = 2'd0;
      bus.dec_rt_addr   = 7'd1;
      bus.dec_reg_write = 1'b1;
      bus.dec_ra_addr   = 7'd0;
      bus.dec_rb_addr   = 7'd0;
      bus.dec_rc_addr   = 7'd0;
      bus.dec_src_use   = 3'b000;
      bus.flush         = 1'b0;
      bus.drain_req     = 1'b0;
      reset             = 1'b1;

      // 1. reset with a valid instruction presented
      repeat (3) @(negedge clk);
      check("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
      check("rst_iss_op",    32'(bus.iss_op), 32'd0);
      check("rst_iss_rt",    32'(bus.iss_rt_addr), 32'd0);
      check("rst_iss_misc",  32'({bus.iss_format, bus.iss_unit, bus.iss_reg_write}), 32'd0);
      check("rst_busy",      32'(bus.busy), 32'd0);
      check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      check("rst_drain_done",32'(bus.drain_done), 32'd0);
      check("rst_dec_ready", 32'(bus.dec_ready), 32'd0);
      bus.dec_valid = 1'b0;
      reset         = 1'b0;
      @(negedge clk);
      send("t1_perm", 2'd0, 7'd1, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 0);
      wait_idle("t1");

      // 2. LocalStore producer, Permute consumer on ra
      base = bus.stall_cnt;
      send("t2_ls",  2'd1, 7'd5, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 0);
      send("t2_dep", 2'd0, 7'd6, 1'b1, 7'd5, 7'd0, 7'd0, 3'b100, 5);
      check("t2_stall_cnt", 32'(bus.stall_cnt - base), 32'd5);
      wait_idle("t2");

      // 3. Branch link result permits back-to-back dependent issue
      base = bus.stall_cnt;
      send("t3_br",  2'd2, 7'd3, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 0);
      send("t3_dep", 2'd0, 7'd8, 1'b1, 7'd0, 7'd3, 7'd0, 3'b010, 0);
      check("t3_stall_cnt", 32'(bus.stall_cnt - base), 32'd0);
      wait_idle("t3");

      // 4. WAW hold, then a non-writing store never stalls or allocates
      send("t4_ls",   2'd1, 7'd9, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 0);
      send("t4_waw",  2'd0, 7'd9, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 5);
      wait_idle("t4a");
      send("t4_store", 2'd1, 7'd9, 1'b0, 7'd20, 7'd21, 7'd22, 3'b111, 0);
      check("t4_store_busy", 32'(bus.busy), 32'd0);
      send("t4_undef", 2'd3, 7'd11, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 0);
      send("t4_rc",    2'd0, 7'd12, 1'b1, 7'd0, 7'd0, 7'd11, 3'b001, 3);
      wait_idle("t4b");
      send("t4_p13",   2'd0, 7'd13, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 0);
      send("t4_unused",2'd0, 7'd14, 1'b1, 7'd40, 7'd13, 7'd41, 3'b101, 0);
      wait_idle("t4c");

      // 5. flush while a dependent is stalled
      send("t5_ls", 2'd1, 7'd7, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 0);
      base = bus.stall_cnt;
      bus.dec_unit      = 2'd0;
      bus.dec_reg_write = 1'b0;
      bus.dec_ra_addr   = 7'd7;
      bus.dec_src_use   = 3'b100;
      bus.dec_valid     = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      #1;
      check("t5_flush_ready", 32'(bus.dec_ready), 32'd0);
      @(negedge clk);
      bus.flush     = 1'b0;
      bus.dec_valid = 1'b0;
      check("t5_stall_cnt", 32'(bus.stall_cnt - base), 32'd2);
      check("t5_busy_t4",   32'(bus.busy), 32'd1);
      @(negedge clk);
      check("t5_busy_t5",   32'(bus.busy), 32'd1);
      @(negedge clk);
      check("t5_busy_t6",   32'(bus.busy), 32'd0);
      wait_idle("t5");

      // 6. drain while a LocalStore is in flight
      send("t6_ls", 2'd1, 7'd4, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 0);
      bus.drain_req     = 1'b1;
      bus.dec_unit      = 2'd0;
      bus.dec_rt_addr   = 7'd30;
      bus.dec_reg_write = 1'b1;
      bus.dec_src_use   = 3'b000;
      bus.dec_valid     = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         #1;
         check($sformatf("t6_ready_%0d", k), 32'(bus.dec_ready), 32'd0);
         check($sformatf("t6_done_%0d", k),  32'(bus.drain_done), (k == 6) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      bus.drain_req = 1'b0;
      send("t6_resume", 2'd0, 7'd30, 1'b1, 7'd0, 7'd0, 7'd0, 3'b000, 1);
      wait_idle("t6");

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
